// File: rtl/traffic_light_param.sv
// Highway/farm-road traffic light controller with internal phase timing,
// farm-green cap, all-red clearance and a night flashing mode.

module traffic_light_param_chk (
   input logic       clk,
   input logic       rst,
   input logic       hg,
   input logic       hy,
   input logic       hr,
   input logic       fg,
   input logic       fy,
   input logic       fr,
   input logic [2:0] state
);

   a_no_conflict: assert property (@(posedge clk) disable iff (!rst)
      !((hg | hy) && (fg | fy)));

   a_onehot_lamps: assert property (@(posedge clk) disable iff (!rst)
      (state != 3'd6) |-> ($onehot({hg, hy, hr}) && $onehot({fg, fy, fr})));

endmodule

module traffic_light_param #(
   parameter int HG_MIN     = 8,
   parameter int FG_MAX     = 6,
   parameter int Y_TIME     = 3,
   parameter int ALL_RED    = 1,
   parameter int FLASH_HALF = 2,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       c,
   input  logic       flash,
   output logic       hg,
   output logic       hy,
   output logic       hr,
   output logic       fg,
   output logic       fy,
   output logic       fr,
   output logic       st,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_HG    = 3'd0,
      S_HY    = 3'd1,
      S_AR1   = 3'd2,
      S_FG    = 3'd3,
      S_FY    = 3'd4,
      S_AR2   = 3'd5,
      S_FLASH = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] HG_LAST = CNT_W'(HG_MIN - 1);
   localparam logic [CNT_W-1:0] FG_LAST = CNT_W'(FG_MAX - 1);
   localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(Y_TIME - 1);
   localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALL_RED - 1);
   localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FLASH_HALF - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Lamp vector order is {hg, hy, hr, fg, fy, fr}; illegal states show all red.
   function automatic logic [5:0] lamp_decode(input state_t s, input logic b);
      logic [5:0] l;
      l = 6'b001001;
      case (s)
         S_HG:    l = 6'b100001;
         S_HY:    l = 6'b010001;
         S_AR1:   l = 6'b001001;
         S_FG:    l = 6'b001100;
         S_FY:    l = 6'b001010;
         S_AR2:   l = 6'b001001;
         S_FLASH: l = {1'b0, b, 1'b0, 1'b0, 1'b0, b};
         default: l = 6'b001001;
      endcase
      return l;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             blink_q, blink_d;
   logic             st_q, st_d;
   logic [5:0]       lamps_q, lamps_d;
   logic             enter_s;
   logic             half_s;

   // Phase sequencing; in HG flash wins over the minimum-green check.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HG: begin
            if (flash || (c && (cnt_q >= HG_LAST))) state_d = S_HY;
            else                                      state_d = S_HG;
         end
         S_HY: begin
            if (cnt_q == Y_LAST) state_d = S_AR1;
            else                 state_d = S_HY;
         end
         S_AR1: begin
            if (cnt_q == AR_LAST) state_d = flash ? S_FLASH : S_FG;
            else                  state_d = S_AR1;
         end
         S_FG: begin
            if (!c || flash || (cnt_q == FG_LAST)) state_d = S_FY;
            else                                   state_d = S_FG;
         end
         S_FY: begin
            if (cnt_q == Y_LAST) state_d = S_AR2;
            else                 state_d = S_FY;
         end
         S_AR2: begin
            if (cnt_q == AR_LAST) state_d = flash ? S_FLASH : S_HG;
            else                  state_d = S_AR2;
         end
         S_FLASH: begin
            if (!flash) state_d = S_AR2;
            else        state_d = S_FLASH;
         end
         default: state_d = S_AR2;
      endcase
   end

   // Phase counter, blink phase, entry pulse and next lamp pattern.
   always_comb begin
      enter_s = (state_d != state_q);
      half_s  = (state_q == S_FLASH) && (cnt_q == FL_LAST);
      cnt_d   = cnt_q;
      blink_d = blink_q;
      if (enter_s) begin
         cnt_d   = {CNT_W{1'b0}};
         blink_d = 1'b1;
      end else if (half_s) begin
         cnt_d   = {CNT_W{1'b0}};
         blink_d = ~blink_q;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         blink_d = blink_q;
      end else begin
         cnt_d   = cnt_q;
         blink_d = blink_q;
      end
      st_d    = enter_s;
      lamps_d = lamp_decode(state_d, blink_d);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_HG;
         cnt_q   <= {CNT_W{1'b0}};
         blink_q <= 1'b1;
         st_q    <= 1'b0;
         lamps_q <= 6'b100001;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
         st_q    <= st_d;
         lamps_q <= lamps_d;
      end
   end

   assign {hg, hy, hr, fg, fy, fr} = lamps_q;
   assign st    = st_q;
   assign state = state_q;

   traffic_light_param_chk u_chk (
      .clk   (clk),
      .rst   (rst),
      .hg    (hg),
      .hy    (hy),
      .hr    (hr),
      .fg    (fg),
      .fy    (fy),
      .fr    (fr),
      .state (state)
   );

endmodule

// File: tb/tb_traffic_light_param.sv
// Scoreboard bench for traffic_light_param: a reference model pushes expected
// state/lamps/st per driven cycle, popped and compared one time unit after the edge.

module tb_traffic_light_param;

   localparam int HG_MIN = 8, FG_MAX = 6, Y_TIME = 3, ALL_RED = 1, FLASH_HALF = 2;
   localparam int HG = 0, HY = 1, AR1 = 2, FG = 3, FY = 4, AR2 = 5, FL = 6;

   logic clk, rst, c, flash;
   logic hg, hy, hr, fg, fy, fr, st;
   logic [2:0] state;

   typedef struct {
      logic [2:0] s;
      logic [5:0] lamps;
      logic       pulse;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   m_state, m_cnt;
   logic m_blink, m_st;

   traffic_light_param dut (
      .clk(clk), .rst(rst), .c(c), .flash(flash),
      .hg(hg), .hy(hy), .hr(hr), .fg(fg), .fy(fy), .fr(fr),
      .st(st), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] exp_lamps(input int s, input logic b);
      case (s)
         HG:      return 6'b100001;
         HY:      return 6'b010001;
         FG:      return 6'b001100;
         FY:      return 6'b001010;
         FL:      return {1'b0, b, 3'b000, b};
         default: return 6'b001001;
      endcase
   endfunction

   task automatic model_edge(input logic r, input logic cc, input logic fl);
      int nxt;
      if (!r) begin
         m_state = HG; m_cnt = 0; m_blink = 1'b1; m_st = 1'b0;
         return;
      end
      nxt = m_state;
      case (m_state)
         HG:  if (fl || (cc && m_cnt >= HG_MIN - 1)) nxt = HY;
         HY:  if (m_cnt == Y_TIME - 1) nxt = AR1;
         AR1: if (m_cnt == ALL_RED - 1) nxt = fl ? FL : FG;
         FG:  if (!cc || fl || m_cnt == FG_MAX - 1) nxt = FY;
         FY:  if (m_cnt == Y_TIME - 1) nxt = AR2;
         AR2: if (m_cnt == ALL_RED - 1) nxt = fl ? FL : HG;
         FL:  if (!fl) nxt = AR2;
         default: nxt = AR2;
      endcase
      if (nxt != m_state) begin
         m_st = 1'b1; m_cnt = 0; m_blink = 1'b1;
      end else begin
         m_st = 1'b0;
         if (m_state == FL && m_cnt == FLASH_HALF - 1) begin
            m_blink = ~m_blink; m_cnt = 0;
         end else if (m_cnt < 255) begin
            m_cnt = m_cnt + 1;
         end
      end
      m_state = nxt;
   endtask

   task automatic step(input logic r, input logic cc, input logic fl);
      exp_t e;
      @(negedge clk);
      rst = r; c = cc; flash = fl;
      model_edge(r, cc, fl);
      e.s = 3'(m_state); e.lamps = exp_lamps(m_state, m_blink); e.pulse = m_st;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_assert++;
      assert (state === e.s) else begin
         n_fail++; $error("FAIL state observed=%0d expected=%0d", state, e.s);
      end
      n_assert++;
      assert ({hg, hy, hr, fg, fy, fr} === e.lamps) else begin
         n_fail++; $error("FAIL lamps observed=%b expected=%b", {hg, hy, hr, fg, fy, fr}, e.lamps);
      end
      n_assert++;
      assert (st === e.pulse) else begin
         n_fail++; $error("FAIL st observed=%b expected=%b", st, e.pulse);
      end
      n_assert++;
      assert (((hg | hy) & (fg | fy)) === 1'b0) else begin
         n_fail++; $error("FAIL conflict observed=%b expected=0", (hg | hy) & (fg | fy));
      end
   endtask

   task automatic check(input string tag, input int obs, input int expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   initial begin
      int   seq[$];
      int   lens[7];
      int   sts[7];
      int   cnt_a;
      int   dw_hg, dw_fg, prev;
      logic fl_r, c_r;
      logic [5:0] pat;

      rst = 1'b0; c = 1'b0; flash = 1'b0;
      m_state = HG; m_cnt = 0; m_blink = 1'b1; m_st = 1'b0;

      // 1: idle highway green
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("reset_state", int'(state), HG);
      check("reset_lamps", int'({hg, hy, hr, fg, fy, fr}), 6'b100001);
      cnt_a = 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (state == 3'd0 && st == 1'b0) cnt_a++;
      end
      check("idle_hg_cycles", cnt_a, 30);

      // 2: full cycle with car present from reset, against a phase table
      step(1'b0, 1'b0, 1'b0);
      lens = '{7, 3, 1, 6, 3, 1, 1};
      sts  = '{HG, HY, AR1, FG, FY, AR2, HG};
      for (int p = 0; p < 7; p++)
         for (int k = 0; k < lens[p]; k++) seq.push_back(sts[p]);
      for (int i = 0; i < seq.size(); i++) begin
         step(1'b1, 1'b1, 1'b0);
         check("cycle_state", int'(state), seq[i]);
         check("cycle_st", int'(st), (i > 0 && seq[i] != seq[i-1]) ? 1 : 0);
      end

      // 3: car leaves in second FG cycle
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40 && state != 3'd3; i++) step(1'b1, 1'b1, 1'b0);
      check("fg_reached", int'(state), FG);
      step(1'b1, 1'b1, 1'b0);
      check("fg_second", int'(state), FG);
      step(1'b1, 1'b0, 1'b0);
      check("fg_to_fy", int'(state), FY);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("fy_third", int'(state), FY);
      step(1'b1, 1'b0, 1'b0);
      check("ar2", int'(state), AR2);
      step(1'b1, 1'b0, 1'b0);
      check("back_hg", int'(state), HG);

      // 4: flash request early in HG
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check("flash_hy", int'(state), HY);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
      check("flash_ar1", int'(state), AR1);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 1'b1);
         pat[5-i] = hy;
         check("flash_fr_eq_hy", int'(fr), int'(hy));
         check("flash_others", int'({hg, hr, fg, fy}), 0);
      end
      check("flash_pattern", int'(pat), 6'b110011);
      step(1'b1, 1'b0, 1'b0);
      check("flash_exit_ar2", int'(state), AR2);
      step(1'b1, 1'b0, 1'b0);
      check("flash_exit_hg", int'(state), HG);

      // 5: reset in the middle of FG
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40 && state != 3'd3; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("midreset_state", int'(state), HG);
      check("midreset_lamps", int'({hg, hy, hr, fg, fy, fr}), 6'b100001);
      check("midreset_st", int'(st), 0);
      cnt_a = 1;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (state == 3'd0) cnt_a++;
         else break;
      end
      check("midreset_hy", int'(state), HY);
      check("midreset_hg_len", cnt_a, HG_MIN);

      // 6: random stimulus with dwell-time invariants
      step(1'b0, 1'b0, 1'b0);
      dw_hg = 1; dw_fg = 0; fl_r = 1'b0; c_r = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 39) == 0) fl_r = ~fl_r;
         if ($urandom_range(0, 4) == 0)  c_r  = ~c_r;
         prev = int'(state);
         step(1'b1, c_r, fl_r);
         if (prev == HG && state == 3'd1 && !fl_r) check("hg_min_dwell", int'(dw_hg >= HG_MIN), 1);
         if (prev == FG && state != 3'd3) check("fg_max_dwell", int'(dw_fg <= FG_MAX), 1);
         dw_hg = (state == 3'd0) ? ((prev == HG) ? dw_hg + 1 : 1) : 0;
         dw_fg = (state == 3'd3) ? ((prev == FG) ? dw_fg + 1 : 1) : 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
